// File: rtl/dcache_flush_unit_if.sv
// ---------------------------------------------------------------------------
// dcache_flush_unit_if
//   Bundles the flush handshake, the metadata-array port and the writeback
//   port of the D$ flush walker.
//   master : the flush unit (drives ack/busy, metadata and writeback requests)
//   slave  : the surrounding cache (controller, tag/state arbiter, miss/wb unit)
//   Signals:
//     flush_i       level flush request, held until flush_ack_o
//     flush_ack_o   one-cycle completion pulse
//     busy_o        walk in progress
//     meta_req_o / meta_we_o / meta_set_o / meta_gnt_i   metadata array port
//     meta_valid_i / meta_dirty_i / meta_tag_i           read data, 1 cycle after grant
//     wb_req_o / wb_addr_o / wb_way_o / wb_gnt_i / wb_done_i   writeback port
// ---------------------------------------------------------------------------
interface dcache_flush_unit_if #(
  parameter int NUM_SETS = 256,
  parameter int NUM_WAYS = 4,
  parameter int TAG_W    = 44,
  parameter int OFFSET_W = 4
);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int ADDR_W = TAG_W + IDX_W + OFFSET_W;

  logic                      flush_i;
  logic                      flush_ack_o;
  logic                      busy_o;
  logic                      meta_req_o;
  logic                      meta_we_o;
  logic [IDX_W-1:0]          meta_set_o;
  logic                      meta_gnt_i;
  logic [NUM_WAYS-1:0]       meta_valid_i;
  logic [NUM_WAYS-1:0]       meta_dirty_i;
  logic [NUM_WAYS*TAG_W-1:0] meta_tag_i;
  logic                      wb_req_o;
  logic [ADDR_W-1:0]         wb_addr_o;
  logic [WAY_W-1:0]          wb_way_o;
  logic                      wb_gnt_i;
  logic                      wb_done_i;

  modport master (
    input  flush_i,
    output flush_ack_o,
    output busy_o,
    output meta_req_o,
    output meta_we_o,
    output meta_set_o,
    input  meta_gnt_i,
    input  meta_valid_i,
    input  meta_dirty_i,
    input  meta_tag_i,
    output wb_req_o,
    output wb_addr_o,
    output wb_way_o,
    input  wb_gnt_i,
    input  wb_done_i
  );

  modport slave (
    output flush_i,
    input  flush_ack_o,
    input  busy_o,
    input  meta_req_o,
    input  meta_we_o,
    input  meta_set_o,
    output meta_gnt_i,
    output meta_valid_i,
    output meta_dirty_i,
    output meta_tag_i,
    input  wb_req_o,
    input  wb_addr_o,
    input  wb_way_o,
    output wb_gnt_i,
    output wb_done_i
  );
endinterface

// File: rtl/dcache_flush_unit.sv
// ---------------------------------------------------------------------------
// dcache_flush_unit
//   Responder for the controller's D$ flush request (fence / fence.i).
//   Walks every set of the write-back D$ metadata array: reads the set,
//   writes back each valid+dirty way (lowest way first) through the
//   miss/writeback unit, then invalidates the whole set. After the last set
//   it pulses flush_ack_o for one cycle and waits for flush_i to drop.
//   Ports:
//     clk_i   clock
//     rst_i   asynchronous active-high reset; aborts a walk without ack
//     bus     dcache_flush_unit_if.master (handshake, metadata, writeback)
// ---------------------------------------------------------------------------
module dcache_flush_unit #(
  parameter int NUM_SETS = 256,
  parameter int NUM_WAYS = 4,
  parameter int TAG_W    = 44,
  parameter int OFFSET_W = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  dcache_flush_unit_if.master    bus
);

  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int ADDR_W = TAG_W + IDX_W + OFFSET_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CHECK,
    S_WB_REQ,
    S_WB_WAIT,
    S_INVAL,
    S_ACK,
    S_HOLD
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [IDX_W-1:0]          r_set;
  logic [NUM_WAYS-1:0]       r_mask;
  logic [NUM_WAYS*TAG_W-1:0] r_tags;

  logic [WAY_W-1:0]          w_way;
  logic [NUM_WAYS-1:0]       w_way_oh;
  logic [NUM_WAYS-1:0]       w_mask_rem;
  logic [NUM_WAYS-1:0]       w_meta_mask;
  logic [TAG_W-1:0]          w_tag;
  logic                      w_last_set;

  // Index of the lowest set bit; the scan runs downward so the last hit wins.
  function automatic logic [WAY_W-1:0] f_lowest_way(input logic [NUM_WAYS-1:0] mask);
    logic [WAY_W-1:0] way;
    way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (mask[w]) way = WAY_W'(w);
    end
    return way;
  endfunction

  // Isolates the lowest set bit (two's complement trick).
  function automatic logic [NUM_WAYS-1:0] f_lowest_onehot(input logic [NUM_WAYS-1:0] mask);
    return mask & (~mask + NUM_WAYS'(1));
  endfunction

  assign w_way       = f_lowest_way(r_mask);
  assign w_way_oh    = f_lowest_onehot(r_mask);
  assign w_mask_rem  = r_mask & ~w_way_oh;
  assign w_meta_mask = bus.meta_valid_i & bus.meta_dirty_i;
  assign w_tag       = r_tags[int'(w_way)*TAG_W +: TAG_W];
  assign w_last_set  = (r_set == IDX_W'(NUM_SETS - 1));

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Walk control: set counter and pending-writeback mask
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_set  <= '0;
      r_mask <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.flush_i) r_set <= '0;
        end
        S_CHECK: begin
          r_mask <= w_meta_mask;
        end
        S_WB_WAIT: begin
          if (bus.wb_done_i) r_mask <= w_mask_rem;
        end
        S_INVAL: begin
          // The counter stops on the last set; it never wraps.
          if (bus.meta_gnt_i && !w_last_set) r_set <= r_set + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Tag capture: only meaningful while r_mask has bits set, so no reset needed
  always_ff @(posedge clk_i) begin
    if (r_state == S_CHECK) r_tags <= bus.meta_tag_i;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.flush_i) w_next = S_READ;
      S_READ:    if (bus.meta_gnt_i) w_next = S_CHECK;
      S_CHECK:   w_next = (w_meta_mask != '0) ? S_WB_REQ : S_INVAL;
      S_WB_REQ:  if (bus.wb_gnt_i) w_next = S_WB_WAIT;
      S_WB_WAIT: begin
        if (bus.wb_done_i) w_next = (w_mask_rem != '0) ? S_WB_REQ : S_INVAL;
      end
      S_INVAL: begin
        if (bus.meta_gnt_i) w_next = w_last_set ? S_ACK : S_READ;
      end
      S_ACK:     w_next = S_HOLD;
      // The controller's request is still high the cycle after ack; wait it out.
      S_HOLD:    if (!bus.flush_i) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Outputs: Moore, and forced to zero outside the state that owns them
  always_comb begin
    bus.flush_ack_o = 1'b0;
    bus.busy_o      = 1'b0;
    bus.meta_req_o  = 1'b0;
    bus.meta_we_o   = 1'b0;
    bus.meta_set_o  = '0;
    bus.wb_req_o    = 1'b0;
    bus.wb_addr_o   = '0;
    bus.wb_way_o    = '0;
    case (r_state)
      S_READ: begin
        bus.busy_o     = 1'b1;
        bus.meta_req_o = 1'b1;
        bus.meta_set_o = r_set;
      end
      S_CHECK: begin
        bus.busy_o = 1'b1;
      end
      S_WB_REQ: begin
        bus.busy_o    = 1'b1;
        bus.wb_req_o  = 1'b1;
        bus.wb_way_o  = w_way;
        bus.wb_addr_o = ADDR_W'({w_tag, r_set, {OFFSET_W{1'b0}}});
      end
      S_WB_WAIT: begin
        bus.busy_o = 1'b1;
      end
      S_INVAL: begin
        bus.busy_o     = 1'b1;
        bus.meta_req_o = 1'b1;
        bus.meta_we_o  = 1'b1;
        bus.meta_set_o = r_set;
      end
      S_ACK: begin
        bus.busy_o      = 1'b1;
        bus.flush_ack_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_flush_unit.sv
// ---------------------------------------------------------------------------
// tb_dcache_flush_unit
//   Bench for dcache_flush_unit with NUM_SETS=4, NUM_WAYS=2, TAG_W=8,
//   OFFSET_W=4. A small metadata-array model answers reads one cycle after
//   grant and clears a set on an invalidate; a writeback model pulses
//   wb_done_i a programmable number of cycles after the writeback grant.
//   Each table row preloads the array and lists the hand-derived results.
// ---------------------------------------------------------------------------
module tb_dcache_flush_unit;

  localparam int NS = 4;
  localparam int NW = 2;
  localparam int TW = 8;
  localparam int OW = 4;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  dcache_flush_unit_if #(.NUM_SETS(NS), .NUM_WAYS(NW), .TAG_W(TW), .OFFSET_W(OW)) bus ();

  dcache_flush_unit #(.NUM_SETS(NS), .NUM_WAYS(NW), .TAG_W(TW), .OFFSET_W(OW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Array contents use bit (set*2+way) for valid/dirty, byte (set*2+way) for tags.
  typedef struct {
    logic [7:0]  valid;
    logic [7:0]  dirty;
    logic [63:0] tags;
    int          lat;
    int          mhold;
    int          whold;
    int          exp_ack;
    int          exp_wbs;
    logic [13:0] a0;
    logic        w0;
    logic [13:0] a1;
    logic        w1;
  } vec_t;

  vec_t vecs[6];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [1:0] m_valid [4];
  logic [1:0] m_dirty [4];
  logic [7:0] m_tag   [4][2];

  int          cyc;
  bit          p_rd;
  logic [1:0]  p_set;
  bit          p_wbg;
  int          wb_cnt, wb_lat, meta_hold, wb_hold;
  int          reads, writes, wbs, acks, busy_cnt, rd_exp, wr_exp;
  bit          order_ok, ack_seen;
  logic [13:0] wb_a [4];
  logic        wb_w [4];
  bit          m_stall, w_stall;
  logic [1:0]  m_set_prev;
  logic [13:0] w_addr_prev;
  logic        w_way_prev;

  task automatic check(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
  endtask

  task automatic clear_counters();
    p_rd = 0; p_wbg = 0; wb_cnt = 0;
    reads = 0; writes = 0; wbs = 0; acks = 0; busy_cnt = 0;
    rd_exp = 0; wr_exp = 0; order_ok = 1; ack_seen = 0;
    m_stall = 0; w_stall = 0;
    for (int i = 0; i < 4; i++) begin
      wb_a[i] = '0;
      wb_w[i] = 1'b0;
    end
  endtask

  task automatic load_model(input vec_t v);
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = v.valid[s*2+w];
        m_dirty[s][w] = v.dirty[s*2+w];
        m_tag[s][w]   = v.tags[(s*2+w)*8 +: 8];
      end
    end
  endtask

  // Advance one clock; everything is sampled and driven 1 time unit after the edge.
  task automatic run_cycle();
    @(posedge clk_i);
    #1;
    cyc++;
    // Read data is only valid the cycle after a read grant; garbage otherwise.
    if (p_rd) begin
      bus.meta_valid_i = m_valid[p_set];
      bus.meta_dirty_i = m_dirty[p_set];
      bus.meta_tag_i   = {m_tag[p_set][1], m_tag[p_set][0]};
    end else begin
      bus.meta_valid_i = 2'b11;
      bus.meta_dirty_i = 2'b11;
      bus.meta_tag_i   = 16'hEEEE;
    end
    p_rd = 0;
    if (p_wbg) begin
      wb_cnt = wb_lat;
      p_wbg  = 0;
    end
    if (wb_cnt > 0) begin
      wb_cnt--;
      bus.wb_done_i = (wb_cnt == 0);
    end else begin
      bus.wb_done_i = 1'b0;
    end
    bus.meta_gnt_i = 1'b1;
    if (bus.meta_req_o && !bus.meta_we_o && meta_hold > 0) begin
      bus.meta_gnt_i = 1'b0;
      meta_hold--;
    end
    bus.wb_gnt_i = 1'b1;
    if (bus.wb_req_o && wb_hold > 0) begin
      bus.wb_gnt_i = 1'b0;
      wb_hold--;
    end
    if (m_stall) begin
      check("meta_req_held", int'(bus.meta_req_o), 1);
      check("meta_set_stable", int'(bus.meta_set_o), int'(m_set_prev));
    end
    m_stall    = bus.meta_req_o && !bus.meta_gnt_i;
    m_set_prev = bus.meta_set_o;
    if (w_stall) begin
      check("wb_req_held", int'(bus.wb_req_o), 1);
      check("wb_addr_stable", int'(bus.wb_addr_o), int'(w_addr_prev));
      check("wb_way_stable", int'(bus.wb_way_o), int'(w_way_prev));
    end
    w_stall     = bus.wb_req_o && !bus.wb_gnt_i;
    w_addr_prev = bus.wb_addr_o;
    w_way_prev  = bus.wb_way_o;
    if (bus.meta_req_o && bus.meta_gnt_i) begin
      if (bus.meta_we_o) begin
        if (int'(bus.meta_set_o) != wr_exp) order_ok = 0;
        wr_exp++;
        writes++;
        m_valid[bus.meta_set_o] = 2'b00;
        m_dirty[bus.meta_set_o] = 2'b00;
      end else begin
        if (int'(bus.meta_set_o) != rd_exp) order_ok = 0;
        rd_exp++;
        reads++;
        p_rd  = 1;
        p_set = bus.meta_set_o;
      end
    end
    if (bus.wb_req_o && bus.wb_gnt_i) begin
      if (wbs < 4) begin
        wb_a[wbs] = bus.wb_addr_o;
        wb_w[wbs] = bus.wb_way_o;
      end
      wbs++;
      p_wbg = 1;
    end
    if (bus.flush_ack_o) begin
      acks++;
      ack_seen = 1;
    end
    if (bus.busy_o) busy_cnt++;
  endtask

  // Full flush: flush_i rises at cycle 0, held through the cycle after ack.
  task automatic do_scenario(input int idx);
    vec_t v;
    int   ack_c;
    v = vecs[idx];
    load_model(v);
    clear_counters();
    wb_lat    = v.lat;
    meta_hold = v.mhold;
    wb_hold   = v.whold;
    cyc       = 0;
    ack_c     = -1;
    bus.flush_i = 1'b1;
    while (!ack_seen && cyc < 400) begin
      run_cycle();
      if (ack_seen) ack_c = cyc;
    end
    if (!ack_seen) begin
      chk_cnt++;
      $display("FAIL vec%0d ack_timeout: no flush_ack_o within %0d cycles", idx, cyc);
    end
    check($sformatf("vec%0d ack_cycle", idx), ack_c, v.exp_ack);
    check($sformatf("vec%0d wb_count", idx), wbs, v.exp_wbs);
    check($sformatf("vec%0d reads", idx), reads, NS);
    check($sformatf("vec%0d writes", idx), writes, NS);
    check($sformatf("vec%0d set_order", idx), int'(order_ok), 1);
    check($sformatf("vec%0d busy_cycles", idx), busy_cnt, v.exp_ack);
    if (v.exp_wbs >= 1) begin
      check($sformatf("vec%0d wb0_addr", idx), int'(wb_a[0]), int'(v.a0));
      check($sformatf("vec%0d wb0_way", idx), int'(wb_w[0]), int'(v.w0));
    end
    if (v.exp_wbs >= 2) begin
      check($sformatf("vec%0d wb1_addr", idx), int'(wb_a[1]), int'(v.a1));
      check($sformatf("vec%0d wb1_way", idx), int'(wb_w[1]), int'(v.w1));
    end
    // Tail: request still high one cycle after ack must not start a new walk.
    run_cycle();
    check($sformatf("vec%0d hold_busy", idx), int'(bus.busy_o), 0);
    bus.flush_i = 1'b0;
    run_cycle();
    check($sformatf("vec%0d no_retrigger", idx), int'(bus.meta_req_o), 0);
    run_cycle();
    check($sformatf("vec%0d idle_busy", idx), int'(bus.busy_o), 0);
    check($sformatf("vec%0d ack_pulses", idx), acks, 1);
  endtask

  initial begin
    // valid, dirty, tags, wb latency, meta stall, wb stall, ack cycle, #wb, wb0, way0, wb1, way1
    vecs[0] = '{8'b0000_0000, 8'b0000_0000, 64'h0, 1, 0, 0, 13, 0,
                14'h0, 1'b0, 14'h0, 1'b0};
    vecs[1] = '{8'b0010_0000, 8'b0010_0000, 64'h0000_A500_0000_0000, 3, 0, 0, 17, 1,
                {8'hA5, 2'd2, 4'h0}, 1'b1, 14'h0, 1'b0};
    vecs[2] = '{8'b0000_1100, 8'b0000_1100, 64'h0000_0000_2211_0000, 2, 0, 0, 19, 2,
                {8'h11, 2'd1, 4'h0}, 1'b0, {8'h22, 2'd1, 4'h0}, 1'b1};
    vecs[3] = '{8'b1111_1101, 8'b0000_0010, 64'h0123_4567_89AB_CDEF, 1, 0, 0, 13, 0,
                14'h0, 1'b0, 14'h0, 1'b0};
    vecs[4] = '{8'b0010_0000, 8'b0010_0000, 64'h0000_A500_0000_0000, 2, 3, 5, 24, 1,
                {8'hA5, 2'd2, 4'h0}, 1'b1, 14'h0, 1'b0};
    vecs[5] = '{8'b0000_0100, 8'b0000_0100, 64'h0000_0000_0077_0000, 2, 0, 0, 16, 1,
                {8'h77, 2'd1, 4'h0}, 1'b0, 14'h0, 1'b0};

    rst_i            = 1'b1;
    bus.flush_i      = 1'b0;
    bus.meta_gnt_i   = 1'b1;
    bus.wb_gnt_i     = 1'b1;
    bus.wb_done_i    = 1'b0;
    bus.meta_valid_i = 2'b11;
    bus.meta_dirty_i = 2'b11;
    bus.meta_tag_i   = 16'hEEEE;
    wb_lat = 1; meta_hold = 0; wb_hold = 0; cyc = 0;
    clear_counters();

    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ack", int'(bus.flush_ack_o), 0);
    check("rst_busy", int'(bus.busy_o), 0);
    check("rst_meta_req", int'(bus.meta_req_o), 0);
    check("rst_meta_set", int'(bus.meta_set_o), 0);
    check("rst_wb_req", int'(bus.wb_req_o), 0);
    check("rst_wb_addr", int'(bus.wb_addr_o), 0);
    rst_i = 1'b0;
    run_cycle();
    run_cycle();

    for (int i = 0; i < 5; i++) do_scenario(i);

    // Reset while waiting for a writeback: outputs drop, no ack, next walk restarts at set 0.
    load_model(vecs[5]);
    clear_counters();
    wb_lat = 20; meta_hold = 0; wb_hold = 0; cyc = 0;
    bus.flush_i = 1'b1;
    while (wbs == 0 && cyc < 100) run_cycle();
    check("rstw_wb_granted", wbs, 1);
    run_cycle();
    check("rstw_in_wait_busy", int'(bus.busy_o), 1);
    bus.flush_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check("rstw_busy", int'(bus.busy_o), 0);
    check("rstw_meta_req", int'(bus.meta_req_o), 0);
    check("rstw_wb_req", int'(bus.wb_req_o), 0);
    check("rstw_ack", int'(bus.flush_ack_o), 0);
    run_cycle();
    rst_i  = 1'b0;
    wb_cnt = 0;
    repeat (5) run_cycle();
    check("rstw_no_ack", acks, 0);
    check("rstw_idle_busy", int'(bus.busy_o), 0);
    do_scenario(5);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
